// File: rtl/pamat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pamat_pkg
// Purpose  : Shared types and default sizes for the moja_pamat FIFO
//            controller and its output buffer.
// Contents : c_ADDRW_DEFAULT / c_DATAW_DEFAULT - default RAM address/data width
//            ptr_t  - RAM pointer at the default address width
//            cnt_t  - word counter at the default address width (one extra bit)
//            gnt_e  - single-port RAM grant per cycle
// Revision : 1.0 - initial release
// ============================================================================
package pamat_pkg;

    localparam int c_ADDRW_DEFAULT = 10;
    localparam int c_DATAW_DEFAULT = 16;

    typedef logic [c_ADDRW_DEFAULT-1:0] ptr_t;
    typedef logic [c_ADDRW_DEFAULT:0]   cnt_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

endpackage
`default_nettype wire

// File: rtl/pamat_outbuf.sv
`default_nettype none
// ============================================================================
// Module   : pamat_outbuf
// Purpose  : 2-entry valid/ready skid FIFO that catches RAM read data one
//            cycle after the read is issued. Entry 0 is always the head.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            push, push_data - write one word (captured RAM data)
//            pop             - head word consumed this cycle
//            occ             - number of valid entries (0..2)
//            data, valid     - head word and its valid flag
// Revision : 1.0 - initial release
// ============================================================================
module pamat_outbuf
    import pamat_pkg::*;
#(
    parameter int dataw = c_DATAW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [dataw-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [dataw-1:0] data,
    output logic             valid
);

    logic [dataw-1:0] r_e0;
    logic [dataw-1:0] r_e1;
    logic [1:0]       r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0  <= '0;
            r_e1  <= '0;
            r_occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    // Upstream read credit guarantees no push into a full buffer.
                    if (r_occ == 2'd0) begin
                        r_e0  <= push_data;
                        r_occ <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_e1  <= push_data;
                        r_occ <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_occ != 2'd0) begin
                        r_e0  <= r_e1;
                        r_occ <= r_occ - 2'd1;
                    end
                end
                2'b11: begin
                    // Pop and capture together: occupancy holds, new word goes last.
                    if (r_occ == 2'd2) begin
                        r_e0 <= r_e1;
                        r_e1 <= push_data;
                    end else if (r_occ == 2'd1) begin
                        r_e0 <= push_data;
                    end else begin
                        r_e0  <= push_data;
                        r_occ <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occ   = r_occ;
    assign data  = r_e0;
    assign valid = (r_occ != 2'd0);

endmodule
`default_nettype wire

// File: rtl/pamat_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pamat_fifo_ctrl
// Purpose  : Stream FIFO controller in front of the single-port synchronous
//            RAM moja_pamat. Arbitrates one RAM access per cycle between the
//            write stream and read-ahead into a 2-entry output buffer.
// Ports    : CLK, RST                       - clock, async active-low reset
//            IN_DATA/IN_VALID/IN_READY      - upstream write stream
//            OUT_DATA/OUT_VALID/OUT_READY   - downstream read stream
//            MEM_ADDR/MEM_DATAIN/MEM_WRITE/MEM_ENABLE/MEM_DATAOUT - RAM port
//            LEVEL                          - words held (RAM + in flight + buffer)
//            FULL, EMPTY                    - RAM full / nothing held at all
// Revision : 1.0 - initial release
// ============================================================================
module pamat_fifo_ctrl
    import pamat_pkg::*;
#(
    parameter int addrw = c_ADDRW_DEFAULT,
    parameter int dataw = c_DATAW_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [dataw-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [dataw-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [addrw-1:0] MEM_ADDR,
    output logic [dataw-1:0] MEM_DATAIN,
    output logic             MEM_WRITE,
    output logic             MEM_ENABLE,
    input  logic [dataw-1:0] MEM_DATAOUT,
    output logic [addrw+1:0] LEVEL,
    output logic             FULL,
    output logic             EMPTY
);

    localparam logic [addrw:0] c_depth = {1'b1, {addrw{1'b0}}};

    logic [addrw-1:0] r_wr_ptr;
    logic [addrw-1:0] r_rd_ptr;
    logic [addrw:0]   r_count;
    logic             r_rd_pend;
    logic             r_rr;

    logic [1:0]       w_occ;
    logic             w_pop;
    logic [2:0]       w_credit;
    logic             w_rd_want;
    logic             w_wr_want;
    logic             w_full;
    gnt_e             w_gnt;

    assign w_full = (r_count == c_depth);
    assign w_pop  = OUT_VALID & OUT_READY;

    // Words already headed for the buffer; a read may only be issued if the
    // buffer still has room after this cycle's pop.
    assign w_credit  = {1'b0, w_occ} + {2'b00, r_rd_pend};
    assign w_rd_want = (r_count != '0) && (w_credit < (3'd2 + {2'b00, w_pop}));
    assign w_wr_want = IN_VALID & ~w_full;

    // On a tie, the side that did not get the previous grant wins.
    always_comb begin
        w_gnt = GNT_NONE;
        if (RST) begin
            if (w_rd_want && (!w_wr_want || !r_rr)) begin
                w_gnt = GNT_RD;
            end else if (w_wr_want) begin
                w_gnt = GNT_WR;
            end
        end
    end

    // IN_VALID only matters through the tie rule, which the rr term resolves
    // without a combinational loop.
    assign IN_READY   = RST & ~w_full & ~(w_rd_want & ~r_rr);
    assign MEM_ENABLE = (w_gnt != GNT_NONE);
    assign MEM_WRITE  = (w_gnt == GNT_WR);
    assign MEM_ADDR   = (w_gnt == GNT_RD) ? r_rd_ptr :
                        (w_gnt == GNT_WR) ? r_wr_ptr : '0;
    assign MEM_DATAIN = (w_gnt == GNT_WR) ? IN_DATA : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_pend <= 1'b0;
            r_rr      <= 1'b0;
        end else begin
            r_rd_pend <= (w_gnt == GNT_RD);
            case (w_gnt)
                GNT_WR: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_count  <= r_count + 1'b1;
                    r_rr     <= 1'b0;
                end
                GNT_RD: begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_count  <= r_count - 1'b1;
                    r_rr     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // RAM data is valid the cycle after the read was issued.
    pamat_outbuf #(
        .dataw     (dataw)
    ) u_outbuf (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (r_rd_pend),
        .push_data (MEM_DATAOUT),
        .pop       (w_pop),
        .occ       (w_occ),
        .data      (OUT_DATA),
        .valid     (OUT_VALID)
    );

    assign LEVEL = (addrw+2)'(r_count) + (addrw+2)'(r_rd_pend) + (addrw+2)'(w_occ);
    assign FULL  = w_full;
    assign EMPTY = (LEVEL == '0);

endmodule
`default_nettype wire

// File: tb/tb_pamat_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pamat_fifo_ctrl
// Purpose  : Self-checking bench for pamat_fifo_ctrl (addrw=2, dataw=16)
//            with a behavioural RAM beside it and a queue-based FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pamat_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] IN_DATA;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DATAIN;
    logic          MEM_WRITE;
    logic          MEM_ENABLE;
    logic [DW-1:0] MEM_DATAOUT;
    logic [AW+1:0] LEVEL;
    logic          FULL;
    logic          EMPTY;

    always #5 CLK = ~CLK;

    pamat_fifo_ctrl #(.addrw(AW), .dataw(DW)) dut (
        .CLK(CLK), .RST(RST),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .MEM_ADDR(MEM_ADDR), .MEM_DATAIN(MEM_DATAIN), .MEM_WRITE(MEM_WRITE),
        .MEM_ENABLE(MEM_ENABLE), .MEM_DATAOUT(MEM_DATAOUT),
        .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY)
    );

    // Behavioural moja_pamat: registered read data, held until next access.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge CLK) begin
        if (MEM_ENABLE) begin
            if (MEM_WRITE) mem[MEM_ADDR] <= MEM_DATAIN;
            else           MEM_DATAOUT   <= mem[MEM_ADDR];
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: words in RAM, one word in flight, buffered words.
    logic [DW-1:0] ram_q[$];
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] got_q[$];
    bit            pend;
    logic [DW-1:0] pend_w;
    bit            last_rd;
    int            wr_tot, rd_tot;
    bit            m_pop, m_rdw, m_wrw;
    int            m_gnt;       // 0 none, 1 write, 2 read
    int            wraps, last_wa;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        ram_q.delete(); out_q.delete();
        pend = 1'b0; pend_w = '0; last_rd = 1'b0;
        wr_tot = 0; rd_tot = 0;
    endfunction

    function automatic void model_check();
        int nr, no, lvl;
        nr = ram_q.size();
        no = out_q.size();
        m_pop = (no != 0) && OUT_READY;
        m_rdw = (nr != 0) && ((no + int'(pend) - int'(m_pop)) < 2);
        m_wrw = IN_VALID && (nr != DEPTH);
        if (m_rdw && m_wrw) m_gnt = last_rd ? 1 : 2;
        else if (m_rdw)     m_gnt = 2;
        else if (m_wrw)     m_gnt = 1;
        else                m_gnt = 0;
        lvl = nr + int'(pend) + no;
        chk("in_ready", IN_READY, (nr != DEPTH) && !(m_rdw && !last_rd));
        chk("out_valid", OUT_VALID, no != 0);
        if (no != 0) chk("out_data", OUT_DATA, out_q[0]);
        chk("mem_enable", MEM_ENABLE, m_gnt != 0);
        chk("mem_write", MEM_WRITE, m_gnt == 1);
        if (m_gnt == 1) begin
            chk("mem_addr_wr", MEM_ADDR, wr_tot % DEPTH);
            chk("mem_datain", MEM_DATAIN, IN_DATA);
        end
        if (m_gnt == 2) chk("mem_addr_rd", MEM_ADDR, rd_tot % DEPTH);
        chk("level", LEVEL, lvl);
        chk("full", FULL, nr == DEPTH);
        chk("empty", EMPTY, lvl == 0);
    endfunction

    function automatic void model_step();
        if (m_pop) void'(out_q.pop_front());
        if (pend)  out_q.push_back(pend_w);
        pend = (m_gnt == 2);
        if (m_gnt == 2) begin
            pend_w = ram_q.pop_front();
            rd_tot++;
            last_rd = 1'b1;
        end else if (m_gnt == 1) begin
            ram_q.push_back(IN_DATA);
            sent_q.push_back(IN_DATA);
            wr_tot++;
            last_rd = 1'b0;
        end
    endfunction

    // Drive at posedge+1, check at negedge.
    task automatic cyc_a(input logic iv, input logic [DW-1:0] d, input logic ordy);
        IN_VALID = iv; IN_DATA = d; OUT_READY = ordy;
        @(negedge CLK);
        model_check();
        if (MEM_ENABLE && MEM_WRITE) begin
            if (last_wa == DEPTH-1 && int'(MEM_ADDR) == 0) wraps++;
            last_wa = int'(MEM_ADDR);
        end
        if (OUT_VALID && OUT_READY) got_q.push_back(OUT_DATA);
    endtask

    task automatic cyc_b();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy, output bit acc);
        cyc_a(iv, d, ordy);
        acc = (m_gnt == 1);
        cyc_b();
    endtask

    task automatic do_reset();
        RST = 1'b0; IN_VALID = 1'b1; IN_DATA = 16'hFFFF; OUT_READY = 1'b1;
        model_reset();
        #1;
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_mem_enable", MEM_ENABLE, 0);
        chk("rst_mem_write", MEM_WRITE, 0);
        chk("rst_mem_addr", MEM_ADDR, 0);
        chk("rst_mem_datain", MEM_DATAIN, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_level", LEVEL, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        @(posedge CLK); #1;
        RST = 1'b1; IN_VALID = 1'b0;
        got_q.delete(); sent_q.delete();
        wraps = 0; last_wa = -1;
    endtask

    // Drain until nothing is held, bounded.
    task automatic drain(input int budget);
        bit acc;
        for (int k = 0; k < budget; k++) begin
            if (ram_q.size() == 0 && !pend && out_q.size() == 0) break;
            cyc(1'b0, '0, 1'b1, acc);
        end
    endtask

    function automatic void cmp_seq(string nm);
        chk({nm, "_count"}, got_q.size(), sent_q.size());
        for (int k = 0; k < got_q.size() && k < sent_q.size(); k++)
            chk({nm, "_word"}, got_q[k], sent_q[k]);
    endfunction

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_ir;
        logic          e_en;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [AW+1:0] e_lvl;
    } vec_t;

    vec_t tv[12];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [DW-1:0] nxt;

        // Single word then two words with a read/write tie, from reset.
        tv[0]  = '{1'b1, 16'hA5A5, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 16'h0,    4'd0};
        tv[1]  = '{1'b0, 16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0,    4'd1};
        tv[2]  = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0,    4'd1};
        tv[3]  = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 16'hA5A5, 4'd1};
        tv[4]  = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0,    4'd0};
        tv[5]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 16'h0,    4'd0};
        tv[6]  = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 16'h0,    4'd1};
        tv[7]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 16'h0,    4'd1};
        tv[8]  = '{1'b0, 16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 16'h0001, 4'd2};
        tv[9]  = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0,    4'd1};
        tv[10] = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0002, 4'd1};
        tv[11] = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0,    4'd0};

        IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0; RST = 1'b0;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            cyc_a(tv[i].iv, tv[i].d, tv[i].ordy);
            chk("tv_in_ready", IN_READY, tv[i].e_ir);
            chk("tv_mem_enable", MEM_ENABLE, tv[i].e_en);
            chk("tv_mem_write", MEM_WRITE, tv[i].e_wr);
            if (tv[i].e_en) chk("tv_mem_addr", MEM_ADDR, tv[i].e_addr);
            chk("tv_out_valid", OUT_VALID, tv[i].e_ov);
            if (tv[i].e_ov) chk("tv_out_data", OUT_DATA, tv[i].e_od);
            chk("tv_level", LEVEL, tv[i].e_lvl);
            cyc_b();
        end

        // Fill to full with the output stalled, then drain in order.
        do_reset();
        nxt = 16'd1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, nxt, 1'b0, acc);
            if (acc && nxt < 16'd8) nxt++;
        end
        cyc_a(1'b1, nxt, 1'b0);
        chk("fill_level", LEVEL, 6);
        chk("fill_full", FULL, 1);
        chk("fill_in_ready", IN_READY, 0);
        chk("fill_out_valid", OUT_VALID, 1);
        cyc_b();
        drain(40);
        chk("fill_drain_count", got_q.size(), 6);
        for (int k = 0; k < got_q.size() && k < 6; k++)
            chk("fill_drain_word", got_q[k], k + 1);

        // Wrap-around: 20 words with both sides always ready.
        do_reset();
        nxt = 16'h0000;
        for (int i = 0; i < 200 && got_q.size() < 20; i++) begin
            cyc(nxt < 16'd20, nxt, 1'b1, acc);
            if (acc) nxt++;
        end
        chk("wrap_count", got_q.size(), 20);
        for (int k = 0; k < got_q.size() && k < 20; k++)
            chk("wrap_word", got_q[k], k);
        chk("wrap_ptr_wraps", wraps >= 4, 1);

        // Backpressure: OUT_READY toggles every cycle mid-stream.
        do_reset();
        nxt = 16'h0100;
        for (int i = 0; i < 40; i++) begin
            cyc(nxt < 16'h010C, nxt, (i < 6) ? 1'b1 : logic'(i % 2 == 0), acc);
            if (acc) nxt++;
        end
        drain(40);
        cmp_seq("bp");

        // Reset while a read is in flight and the buffer holds data.
        do_reset();
        nxt = 16'h0200;
        for (int i = 0; i < 20; i++) begin
            if (pend && out_q.size() >= 1) break;
            cyc(1'b1, nxt, 1'b0, acc);
            if (acc) nxt++;
        end
        do_reset();
        cyc(1'b1, 16'h1234, 1'b1, acc);
        for (int i = 0; i < 10 && got_q.size() == 0; i++) cyc(1'b0, '0, 1'b1, acc);
        chk("midrst_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("midrst_word", got_q[0], 16'h1234);

        // Randomized traffic: stall-heavy phase, then drain-heavy phase.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic iv, ordy;
            iv   = ($urandom % 4) != 0;
            ordy = (i < 200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            cyc(iv, 16'($urandom), ordy, acc);
        end
        drain(60);
        cmp_seq("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
